// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and the ALU.
// Contents:
//   - field positions of the 29-bit instruction word
//   - opcode values
//   - fetch FSM state encoding
package inst_fetch_pkg;

  localparam int OPC_HI = 28;
  localparam int OPC_LO = 24;
  localparam int RD_HI  = 23;
  localparam int RD_LO  = 20;
  localparam int RS_HI  = 19;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 12;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_ANDI = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction handshake between the fetch stage and the ALU.
// Signals:
//   inst       - instruction word, driven by the fetch stage
//   inst_valid - inst holds an unconsumed instruction
//   inst_ready - consumer accepts inst this cycle
// Modports:
//   master - fetch side (drives inst/inst_valid)
//   slave  - ALU side (drives inst_ready)
interface inst_fetch_if #(
  parameter int INST_W = 29
) ();

  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              inst_ready;

  modport master (
    output inst,
    output inst_valid,
    input  inst_ready
  );

  modport slave (
    input  inst,
    input  inst_valid,
    output inst_ready
  );

endinterface

// File: rtl/inst_fetch_store.sv
// Program store for the fetch stage: DEPTH x INST_W words, synchronous write,
// combinational read. Contents are not affected by reset.
// Ports:
//   clk     - write clock
//   we      - write enable
//   wr_addr - write address
//   wr_data - write data
//   rd_addr - read address
//   rd_data - combinational read data
module inst_store #(
  parameter int INST_W = 29,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_data
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage feeding the ALU.
// A loadable program store is walked by a program counter; each word is
// presented on a valid/ready handshake until a HALT opcode is reached.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   load_en   - write load_data to store[load_addr] (only in IDLE/HALT)
//   load_addr - store write address
//   load_data - store write data
//   start     - one-cycle pulse, begins a run from address 0
//   fb        - instruction handshake to the ALU (master side)
//   pc        - address of the next word to fetch
//   busy      - high while running
//   halted    - high after a HALT word has been reached
// DEPTH must equal 2**ADDR_W so that pc wraps naturally.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int         INST_W  = 29,
  parameter int         ADDR_W  = 8,
  parameter int         DEPTH   = 256,
  parameter logic [4:0] HALT_OP = OP_HALT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [INST_W-1:0] load_data,
  input  logic              start,
  inst_fetch_if.master      fb,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_p0, inst_d;
  logic              vld_p0, vld_d;

  logic [INST_W-1:0] rd_word;
  logic              store_we;
  logic              slot_free;
  logic              word_is_halt;

  // The store is frozen while a run is in progress.
  assign store_we = load_en && (state_q != ST_RUN);

  inst_store #(
    .INST_W (INST_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .clk     (clk),
    .we      (store_we),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (pc_q),
    .rd_data (rd_word)
  );

  assign slot_free    = !vld_p0 || fb.inst_ready;
  assign word_is_halt = (rd_word[OPC_HI:OPC_LO] == HALT_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      inst_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_p0 <= inst_d;
      vld_p0  <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_p0;
    vld_d   = vld_p0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        // A word left pending when HALT was reached still drains normally.
        if (vld_p0 && fb.inst_ready) begin
          vld_d = 1'b0;
        end
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        if (slot_free) begin
          if (!word_is_halt) begin
            inst_d = rd_word;
            vld_d  = 1'b1;
            pc_d   = pc_q + ADDR_W'(1);
          end else begin
            // HALT word is never issued; pc keeps pointing at it.
            state_d = ST_HALT;
            if (fb.inst_ready) begin
              vld_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign fb.inst       = inst_p0;
  assign fb.inst_valid = vld_p0;
  assign pc            = pc_q;
  assign busy          = (state_q == ST_RUN);
  assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int INST_W = 29;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  localparam logic [INST_W-1:0] W_AND  = 29'b00000010111001101000000000000;
  localparam logic [INST_W-1:0] W_ADD  = 29'b00100000100100100000000000000;
  localparam logic [INST_W-1:0] W_HALT = {OP_HALT, 24'h000000};
  localparam logic [INST_W-1:0] W_NEW  = {OP_SLT, 4'h3, 4'h4, 4'h5, 12'h000};
  localparam logic [INST_W-1:0] W_ANDI = {OP_ANDI, 4'h1, 4'h2, 16'h00ff};

  logic              clk;
  logic              rst;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [INST_W-1:0] load_data;
  logic              start;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  inst_fetch_if #(.INST_W(INST_W)) fb_if ();

  inst_fetch #(
    .INST_W (INST_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .fb        (fb_if.master),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  int compared;
  int mismatched;
  logic [INST_W-1:0] hs_log[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed handshake.
  always @(posedge clk) begin
    if (fb_if.inst_valid && fb_if.inst_ready) begin
      hs_log.push_back(fb_if.inst);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [INST_W-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic load_basic();
    load_word(8'd0, W_AND);
    load_word(8'd1, W_ADD);
    load_word(8'd2, W_HALT);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    fb_if.inst_ready = 1'b0;
    tick(); tick();
    compared++;
    if ({fb_if.inst_valid, busy, halted, pc, fb_if.inst} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: valid=%b busy=%b halted=%b pc=%h inst=%h, all required 0",
               fb_if.inst_valid, busy, halted, pc, fb_if.inst);
    end
    rst = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0 || halted !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: busy=%b halted=%b, required 0 0", busy, halted);
    end
  endtask

  task automatic test_basic();
    int base;
    load_basic();
    fb_if.inst_ready = 1'b1;
    base = hs_log.size();
    pulse_start();
    compared++;
    if (busy !== 1'b1 || fb_if.inst_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_cycle1: busy=%b valid=%b, required 1 0", busy, fb_if.inst_valid);
    end
    tick();
    compared++;
    if (fb_if.inst_valid !== 1'b1 || fb_if.inst !== W_AND || pc !== 8'd1) begin
      mismatched++;
      $display("FAIL basic_word0: valid=%b inst=%h pc=%h, required 1 %h 01",
               fb_if.inst_valid, fb_if.inst, pc, W_AND);
    end
    tick();
    compared++;
    if (fb_if.inst_valid !== 1'b1 || fb_if.inst !== W_ADD || pc !== 8'd2) begin
      mismatched++;
      $display("FAIL basic_word1: valid=%b inst=%h pc=%h, required 1 %h 02",
               fb_if.inst_valid, fb_if.inst, pc, W_ADD);
    end
    tick();
    compared++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'd2 || fb_if.inst_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_halt: halted=%b busy=%b pc=%h valid=%b, required 1 0 02 0",
               halted, busy, pc, fb_if.inst_valid);
    end
    compared++;
    if (hs_log.size() - base != 2) begin
      mismatched++;
      $display("FAIL basic_hs_count: got %0d, required 2", hs_log.size() - base);
    end else begin
      compared++;
      if (hs_log[base] !== W_AND || hs_log[base+1] !== W_ADD) begin
        mismatched++;
        $display("FAIL basic_hs_words: got %h %h, required %h %h",
                 hs_log[base], hs_log[base+1], W_AND, W_ADD);
      end
    end
  endtask

  task automatic test_restart();
    pulse_start();
    compared++;
    if (pc !== 8'd0 || busy !== 1'b1 || halted !== 1'b0 || fb_if.inst_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL restart_state: pc=%h busy=%b halted=%b valid=%b, required 00 1 0 0",
               pc, busy, halted, fb_if.inst_valid);
    end
    tick();
    compared++;
    if (fb_if.inst_valid !== 1'b1 || fb_if.inst !== W_AND) begin
      mismatched++;
      $display("FAIL restart_first: valid=%b inst=%h, required 1 %h",
               fb_if.inst_valid, fb_if.inst, W_AND);
    end
    tick(); tick();
    compared++;
    if (halted !== 1'b1) begin
      mismatched++;
      $display("FAIL restart_halt: halted=%b, required 1", halted);
    end
  endtask

  task automatic test_stall();
    int base;
    fb_if.inst_ready = 1'b0;
    pulse_start();
    tick();
    base = hs_log.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (fb_if.inst_valid !== 1'b1 || fb_if.inst !== W_AND || pc !== 8'd1) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: valid=%b inst=%h pc=%h, required 1 %h 01",
                 i, fb_if.inst_valid, fb_if.inst, pc, W_AND);
      end
    end
    fb_if.inst_ready = 1'b1;
    tick();
    compared++;
    if (fb_if.inst_valid !== 1'b1 || fb_if.inst !== W_ADD || pc !== 8'd2) begin
      mismatched++;
      $display("FAIL stall_release: valid=%b inst=%h pc=%h, required 1 %h 02",
               fb_if.inst_valid, fb_if.inst, pc, W_ADD);
    end
    tick();
    compared++;
    if (halted !== 1'b1 || fb_if.inst_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_halt: halted=%b valid=%b, required 1 0", halted, fb_if.inst_valid);
    end
    compared++;
    if (hs_log.size() - base != 2) begin
      mismatched++;
      $display("FAIL stall_hs_count: got %0d, required 2", hs_log.size() - base);
    end else begin
      compared++;
      if (hs_log[base] !== W_AND || hs_log[base+1] !== W_ADD) begin
        mismatched++;
        $display("FAIL stall_hs_words: got %h %h, required %h %h",
                 hs_log[base], hs_log[base+1], W_AND, W_ADD);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    fb_if.inst_ready = 1'b0;
    pulse_start();
    tick();
    compared++;
    if (fb_if.inst_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_pending: valid=%b, required 1", fb_if.inst_valid);
    end
    base = hs_log.size();
    rst = 1'b1;
    #1;
    compared++;
    if ({fb_if.inst_valid, busy, halted, pc, fb_if.inst} !== '0) begin
      mismatched++;
      $display("FAIL rstmid_async: valid=%b busy=%b halted=%b pc=%h inst=%h, all required 0",
               fb_if.inst_valid, busy, halted, pc, fb_if.inst);
    end
    tick();
    rst = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0 || halted !== 1'b0 || hs_log.size() != base) begin
      mismatched++;
      $display("FAIL rstmid_idle: busy=%b halted=%b hs=%0d, required 0 0 %0d",
               busy, halted, hs_log.size(), base);
    end
    fb_if.inst_ready = 1'b1;
    pulse_start();
    tick();
    compared++;
    if (fb_if.inst_valid !== 1'b1 || fb_if.inst !== W_AND) begin
      mismatched++;
      $display("FAIL rstmid_reissue: valid=%b inst=%h, required 1 %h",
               fb_if.inst_valid, fb_if.inst, W_AND);
    end
    tick(); tick();
  endtask

  task automatic test_load_during_run();
    fb_if.inst_ready = 1'b0;
    pulse_start();
    load_word(8'd1, W_NEW);
    tick();
    fb_if.inst_ready = 1'b1;
    tick();
    compared++;
    if (fb_if.inst_valid !== 1'b1 || fb_if.inst !== W_ADD) begin
      mismatched++;
      $display("FAIL load_in_run: valid=%b inst=%h, required 1 %h",
               fb_if.inst_valid, fb_if.inst, W_ADD);
    end
    tick();
    compared++;
    if (halted !== 1'b1) begin
      mismatched++;
      $display("FAIL load_in_run_halt: halted=%b, required 1", halted);
    end
  endtask

  task automatic test_wrap();
    int base;
    logic [INST_W-1:0] w255;
    for (int i = 0; i < DEPTH; i++) begin
      load_word(ADDR_W'(i), (i == 0) ? W_ANDI : {OP_ADD, 24'(i)});
    end
    w255 = {OP_ADD, 24'd255};
    fb_if.inst_ready = 1'b1;
    pulse_start();
    tick();
    compared++;
    if (fb_if.inst !== W_ANDI || pc !== 8'd1) begin
      mismatched++;
      $display("FAIL wrap_first: inst=%h pc=%h, required %h 01", fb_if.inst, pc, W_ANDI);
    end
    repeat (255) tick();
    compared++;
    if (fb_if.inst !== w255 || pc !== 8'd0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_last: inst=%h pc=%h busy=%b, required %h 00 1",
               fb_if.inst, pc, busy, w255);
    end
    tick();
    compared++;
    if (fb_if.inst_valid !== 1'b1 || fb_if.inst !== W_ANDI || pc !== 8'd1) begin
      mismatched++;
      $display("FAIL wrap_reissue: valid=%b inst=%h pc=%h, required 1 %h 01",
               fb_if.inst_valid, fb_if.inst, pc, W_ANDI);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    load_word(8'd0, W_HALT);
    base = hs_log.size();
    pulse_start();
    tick();
    compared++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'd0 || fb_if.inst_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL halt_at_0: halted=%b busy=%b pc=%h valid=%b, required 1 0 00 0",
               halted, busy, pc, fb_if.inst_valid);
    end
    compared++;
    if (hs_log.size() != base) begin
      mismatched++;
      $display("FAIL halt_at_0_hs: got %0d handshakes, required 0", hs_log.size() - base);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_basic();
    test_restart();
    test_stall();
    test_reset_mid();
    test_load_during_run();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
